// File: rtl/stream_scoreboard.sv
// stream_scoreboard
//   Self-checking scoreboard for multi-lane (unfolded) stream outputs.
//   Expected beats are queued in a FIFO; each DUT output beat pops the head
//   and is compared lane by lane. Tracks match/error/unexpected counts,
//   first-failure capture and a stall timeout.
//
// Ports:
//   CLK, RST         clock (rising edge), asynchronous active-high reset
//   START            one-cycle pulse: (re)start a check, clears everything
//   EXP_VIN/DIN/LAST expected beat input; EXP_READY = FIFO can accept
//   DUT_VIN/DIN      DUT output beat (no backpressure)
//   ERR_CNT, MATCH_CNT, UNEXP_CNT     saturating lane/beat statistics
//   FIRST_ERR_BEAT/LANE/EXP/GOT       capture of the first mismatching beat
//   TIMED_OUT, DONE, PASS             completion status (held until START/RST)
module stream_scoreboard #(
    parameter  int WIDTH   = 11,
    parameter  int LANES   = 3,
    parameter  int DEPTH   = 16,
    parameter  int CNT_W   = 16,
    parameter  int TIMEOUT = 1024,
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic                    EXP_VIN,
    input  logic [LANES*WIDTH-1:0]  EXP_DIN,
    input  logic                    EXP_LAST,
    output logic                    EXP_READY,
    input  logic                    DUT_VIN,
    input  logic [LANES*WIDTH-1:0]  DUT_DIN,
    output logic [CNT_W-1:0]        ERR_CNT,
    output logic [CNT_W-1:0]        MATCH_CNT,
    output logic [CNT_W-1:0]        UNEXP_CNT,
    output logic [CNT_W-1:0]        FIRST_ERR_BEAT,
    output logic [LANE_W-1:0]       FIRST_ERR_LANE,
    output logic [WIDTH-1:0]        FIRST_ERR_EXP,
    output logic [WIDTH-1:0]        FIRST_ERR_GOT,
    output logic                    TIMED_OUT,
    output logic                    DONE,
    output logic                    PASS
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [32:0] CNT_MAX = (33'd1 << CNT_W) - 33'd1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state;

    logic [LANES*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count, count_nx;
    logic [TW-1:0]          tcnt;
    logic [CNT_W-1:0]       beat_idx;

    logic active, empty, full, push, pop, unexp, tick, tmo;
    logic [LANES*WIDTH-1:0] head;
    logic [WIDTH-1:0]       e_lane, g_lane, low_exp, low_got;
    logic [LANE_W-1:0]      low_lane;
    logic                   found;
    logic [31:0]            n_mis, n_match;
    logic [CNT_W-1:0]       err_nx, unexp_nx;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [31:0] b);
        logic [32:0] s;
        s = 33'(a) + 33'(b);
        if (s > CNT_MAX) sat_add = '1;
        else             sat_add = s[CNT_W-1:0];
    endfunction

    assign active    = (state == S_RUN) || (state == S_DRAIN);
    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign EXP_READY = (state == S_RUN) && !full;
    assign push      = EXP_VIN && EXP_READY;
    assign pop       = DUT_VIN && active && !empty;
    assign unexp     = DUT_VIN && active && empty;
    assign tick      = active && !empty && !DUT_VIN;
    assign tmo       = tick && (tcnt == TW'(TIMEOUT - 1));
    assign count_nx  = count + (AW+1)'(push) - (AW+1)'(pop);

    // Lane-wise compare of the FIFO head; the first mismatch found while
    // scanning upward is the lowest lane index.
    always_comb begin
        head     = mem[rd_ptr];
        e_lane   = '0;
        g_lane   = '0;
        n_mis    = '0;
        found    = 1'b0;
        low_lane = '0;
        low_exp  = '0;
        low_got  = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            e_lane = head[k*WIDTH +: WIDTH];
            g_lane = DUT_DIN[k*WIDTH +: WIDTH];
            if (e_lane != g_lane) begin
                n_mis = n_mis + 32'd1;
                if (!found) begin
                    found    = 1'b1;
                    low_lane = LANE_W'(k);
                    low_exp  = e_lane;
                    low_got  = g_lane;
                end
            end
        end
        n_match  = 32'(LANES) - n_mis;
        err_nx   = pop   ? sat_add(ERR_CNT, n_mis)     : ERR_CNT;
        unexp_nx = unexp ? sat_add(UNEXP_CNT, 32'd1)   : UNEXP_CNT;
    end

    // FIFO storage carries no reset; validity is tracked by count.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= EXP_DIN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            tcnt           <= '0;
            beat_idx       <= '0;
            ERR_CNT        <= '0;
            MATCH_CNT      <= '0;
            UNEXP_CNT      <= '0;
            FIRST_ERR_BEAT <= '0;
            FIRST_ERR_LANE <= '0;
            FIRST_ERR_EXP  <= '0;
            FIRST_ERR_GOT  <= '0;
            TIMED_OUT      <= 1'b0;
            DONE           <= 1'b0;
            PASS           <= 1'b0;
        end else if (START) begin
            state          <= S_RUN;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            tcnt           <= '0;
            beat_idx       <= '0;
            ERR_CNT        <= '0;
            MATCH_CNT      <= '0;
            UNEXP_CNT      <= '0;
            FIRST_ERR_BEAT <= '0;
            FIRST_ERR_LANE <= '0;
            FIRST_ERR_EXP  <= '0;
            FIRST_ERR_GOT  <= '0;
            TIMED_OUT      <= 1'b0;
            DONE           <= 1'b0;
            PASS           <= 1'b0;
        end else if (active) begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_nx;
            tcnt      <= tick ? tcnt + TW'(1) : '0;
            ERR_CNT   <= err_nx;
            UNEXP_CNT <= unexp_nx;
            if (pop) begin
                MATCH_CNT <= sat_add(MATCH_CNT, n_match);
                beat_idx  <= sat_add(beat_idx, 32'd1);
                // ERR_CNT saturates and never returns to zero, so zero
                // means no mismatch has been captured since START.
                if (n_mis != '0 && ERR_CNT == '0) begin
                    FIRST_ERR_BEAT <= beat_idx;
                    FIRST_ERR_LANE <= low_lane;
                    FIRST_ERR_EXP  <= low_exp;
                    FIRST_ERR_GOT  <= low_got;
                end
            end
            if (tmo) begin
                TIMED_OUT <= 1'b1;
                DONE      <= 1'b1;
                PASS      <= 1'b0;
                state     <= S_DONE;
            end else if (state == S_RUN && push && EXP_LAST) begin
                state <= S_DRAIN;
            end else if (state == S_DRAIN && count_nx == '0) begin
                DONE  <= 1'b1;
                PASS  <= (err_nx == '0) && (unexp_nx == '0);
                state <= S_DONE;
            end
        end
    end

endmodule
